// File: rtl/serial_ripple_adder_if.sv
// Operand/result handshake bundle for serial_ripple_adder.
// slave is the adder side; master is the operand source / result consumer.
interface serial_ripple_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output busy
    );
endinterface

// File: rtl/full_adder.sv
// 1-bit full-adder cell shared by the bit-serial datapaths.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_cin;
    assign o_c = (i_a & i_b) | (i_cin & w_p);
endmodule

// File: rtl/serial_ripple_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB-first, carry held in a register.
// Operands are taken in parallel in IDLE, the result is presented in parallel in DONE.
module serial_ripple_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_ripple_adder_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_d;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CntW-1:0]  r_count;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_sh_d;

    full_adder u_bit_cell (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0]),
        .i_cin(r_carry),
        .o_s  (w_s),
        .o_c  (w_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_step    = 1'b0;
        w_last    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_step = 1'b1;
                if (r_count == LastBit) begin
                    w_last    = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        w_sum_sh_d            = r_sum_sh >> 1;
        w_sum_sh_d[WIDTH-1]   = w_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_sum_sh <= '0;
            r_carry  <= bus.cin;
            r_count  <= '0;
        end else if (w_step) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_sh_d;
            r_carry  <= w_c;
            r_count  <= r_count + 1'b1;
            // Result registers only move on the final bit, so they hold through IDLE.
            if (w_last) begin
                r_sum  <= w_sum_sh_d;
                r_cout <= w_c;
            end
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.busy      = (r_state == StRun) || (r_state == StDone);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_serial_ripple_adder.sv
// Scoreboard bench for serial_ripple_adder at WIDTH 8, 2 and 1 against a+b+cin arithmetic.
module tb_serial_ripple_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_ripple_adder_if #(.WIDTH(8)) bus8 ();
    serial_ripple_adder_if #(.WIDTH(2)) bus2 ();
    serial_ripple_adder_if #(.WIDTH(1)) bus1 ();

    serial_ripple_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_ripple_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    serial_ripple_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat[3]  = '{8, 2, 1};
    int acc[3]  = '{0, 0, 0};
    bit prev_v[3];
    bit hs_q[3];
    bit rand_bp = 1'b0;
    logic [8:0] q[3][$];
    int acc_hist8[$];

    logic       ov[3];
    logic       ordy[3];
    logic       ir[3];
    logic       bsy[3];
    logic [8:0] res[3];

    assign ov[0]   = bus8.out_valid;
    assign ov[1]   = bus2.out_valid;
    assign ov[2]   = bus1.out_valid;
    assign ordy[0] = bus8.out_ready;
    assign ordy[1] = bus2.out_ready;
    assign ordy[2] = bus1.out_ready;
    assign ir[0]   = bus8.in_ready;
    assign ir[1]   = bus2.in_ready;
    assign ir[2]   = bus1.in_ready;
    assign bsy[0]  = bus8.busy;
    assign bsy[1]  = bus2.busy;
    assign bsy[2]  = bus1.busy;
    assign res[0]  = {bus8.cout, bus8.sum};
    assign res[1]  = {6'b0, bus2.cout, bus2.sum};
    assign res[2]  = {7'b0, bus1.cout, bus1.sum};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept-edge bookkeeping: acc holds the cycle number right after the accept edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus8.in_valid && bus8.in_ready) begin
                acc[0] <= cyc + 1;
                acc_hist8.push_back(cyc + 1);
            end
            if (bus2.in_valid && bus2.in_ready) acc[1] <= cyc + 1;
            if (bus1.in_valid && bus1.in_ready) acc[2] <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                prev_v[k] <= 1'b0;
                hs_q[k]   <= 1'b0;
            end else begin
                if (ov[k] && !prev_v[k])
                    chk($sformatf("latency_w%0d", lat[k]), 64'(cyc - acc[k]), 64'(lat[k]));
                if (ov[k] && ordy[k]) begin
                    chk($sformatf("result_expected_w%0d", lat[k]), 64'(q[k].size() != 0), 64'd1);
                    if (q[k].size() != 0)
                        chk($sformatf("result_w%0d", lat[k]), 64'(res[k]), 64'(q[k].pop_front()));
                end
                if (hs_q[k]) begin
                    chk($sformatf("in_ready_after_hs_w%0d", lat[k]), 64'(ir[k]), 64'd1);
                    chk($sformatf("valid_drop_after_hs_w%0d", lat[k]), 64'(ov[k]), 64'd0);
                end
                hs_q[k]   <= ov[k] && ordy[k];
                prev_v[k] <= ov[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic v);
        case (k)
            0: begin bus8.a = a;      bus8.b = b;      bus8.cin = c; bus8.in_valid = v; end
            1: begin bus2.a = a[1:0]; bus2.b = b[1:0]; bus2.cin = c; bus2.in_valid = v; end
            default: begin bus1.a = a[0]; bus1.b = b[0]; bus1.cin = c; bus1.in_valid = v; end
        endcase
    endtask

    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input bit keep, input bit expct);
        logic [15:0] full;
        drive(k, a, b, c, 1'b1);
        for (int i = 0; i < 300 && !ir[k]; i++) begin
            if (rand_bp) bus8.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk($sformatf("accept_wait_w%0d", lat[k]), 64'(ir[k]), 64'd1);
        full = (16'(a) + 16'(b) + 16'(c)) & ((16'd1 << (lat[k] + 1)) - 16'd1);
        if (expct) q[k].push_back(full[8:0]);
        step();
        if (!keep) drive(k, a, b, c, 1'b0);
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 300 && q[k].size() != 0; i++) begin
            if (rand_bp) bus8.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk($sformatf("drain_w%0d", lat[k]), 64'(q[k].size()), 64'd0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 8'h0, 8'h0, 1'b0, 1'b0);
        drive(1, 8'h0, 8'h0, 1'b0, 1'b0);
        drive(2, 8'h0, 8'h0, 1'b0, 1'b0);
        bus8.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready_w%0d", lat[k]), 64'(ir[k]), 64'd1);
            chk($sformatf("rst_out_valid_w%0d", lat[k]), 64'(ov[k]), 64'd0);
            chk($sformatf("rst_busy_w%0d", lat[k]), 64'(bsy[k]), 64'd0);
            chk($sformatf("rst_result_w%0d", lat[k]), 64'(res[k]), 64'd0);
        end
        rst = 1'b0;
        step();

        send(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        drain(0);

        // Backpressure: result must hold while the consumer stalls.
        bus8.out_ready = 1'b0;
        send(0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && !ov[0]; i++) step();
        chk("bp_valid_seen", 64'(ov[0]), 64'd1);
        repeat (5) begin
            chk("bp_result", 64'(res[0]), 64'h100);
            chk("bp_in_ready", 64'(ir[0]), 64'd0);
            chk("bp_busy", 64'(bsy[0]), 64'd1);
            chk("bp_valid", 64'(ov[0]), 64'd1);
            step();
        end
        bus8.out_ready = 1'b1;
        drain(0);

        // Back-to-back with in_valid held high.
        acc_hist8.delete();
        send(0, 8'hA5, 8'h5A, 1'b1, 1'b1, 1'b1);
        send(0, 8'h3C, 8'h42, 1'b0, 1'b0, 1'b1);
        drain(0);
        chk("b2b_accepts", 64'(acc_hist8.size()), 64'd2);
        if (acc_hist8.size() == 2)
            chk("b2b_interval", 64'(acc_hist8[1] - acc_hist8[0]), 64'd10);

        // Asynchronous reset during the third bit cycle.
        send(0, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(ov[0]), 64'd0);
        chk("midrst_result", 64'(res[0]), 64'd0);
        chk("midrst_in_ready", 64'(ir[0]), 64'd1);
        chk("midrst_busy", 64'(bsy[0]), 64'd0);
        step();
        rst = 1'b0;
        step();
        send(0, 8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
        drain(0);

        rand_bp = 1'b1;
        repeat (25) send(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
        drain(0);
        rand_bp = 1'b0;
        bus8.out_ready = 1'b1;
        drain(0);

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    send(1, 8'(a), 8'(b), 1'(c), 1'b0, 1'b1);
        drain(1);

        send(2, 8'h1, 8'h1, 1'b1, 1'b0, 1'b1);
        drain(2);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_ripple_adder.md
Name: serial_ripple_adder

Overview:
- Bit-serial N-bit adder that reuses a single full-adder bit cell once per clock, with a registered carry.
- Operands are accepted in parallel with a valid/ready handshake, processed LSB-first over WIDTH cycles, and returned in parallel.
- Sits directly downstream of the operand source and wraps the team's 1-bit full-adder cell, turning the combinational cell into a sequential multi-bit datapath.
- Targets area-constrained paths where latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set a/b/cin is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum/cout valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits, a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: rst high asynchronously forces the following, regardless of clk:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - sum=0, cout=0
  - internal shift registers, carry register and bit counter all 0.
- Reset mid-operation discards the operation in flight; no partial result is ever presented.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch a, b into shift registers, carry_reg<=cin, count<=0, go to RUN.
  - in_valid=0 leaves state unchanged.
- RUN:
  - in_ready=0; a/b/cin/in_valid are ignored.
  - Each edge: s = a_sh[0]^b_sh[0]^carry_reg; c = (a_sh[0]&b_sh[0]) | (carry_reg&(a_sh[0]^b_sh[0])).
  - sum_sh shifts right with s inserted at the MSB; a_sh and b_sh shift right; carry_reg<=c; count<=count+1.
  - When count reaches WIDTH-1 on an edge (the WIDTH-th bit edge): go to DONE, capture cout<=c and the final sum_sh onto sum.
- Bit cell: the s and c equations above must be bit-exact to the team's 1-bit full-adder cell. The cell is instantiated, not re-derived.
- Counter width: clog2(WIDTH+1). No wrap is possible. WIDTH=1 gives exactly one RUN cycle.
- DONE:
  - out_valid=1; sum and cout are held stable until the handshake.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - out_ready=0 holds DONE indefinitely (backpressure); in_ready stays 0.
- Latency:
  - Accept edge E0; bit edges E1..E_WIDTH.
  - out_valid is high in the cycle after E_WIDTH, i.e. WIDTH cycles after acceptance.
  - Minimum initiation interval is WIDTH+2 cycles with out_ready tied high.
- sum and cout outputs keep their last value in IDLE (not cleared) until the next DONE or a reset.
- Asserting out_ready outside DONE has no effect.
- Asserting in_valid outside IDLE has no effect; the operand is not queued.

Test Plan:
- WIDTH=8, a=0xFF, b=0x01, cin=0, out_ready=1 -> out_valid rises 8 cycles after the accept edge with sum=0x00, cout=1; in_ready returns to 1 one cycle later.
- WIDTH=8, a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0. Both issued back-to-back with in_valid held high: second accept occurs exactly 10 cycles after the first.
- Backpressure: a=0x80, b=0x80, cin=0, out_ready=0 for 5 cycles after out_valid -> sum=0x00, cout=1 held stable, in_ready=0 and busy=1 throughout; out_ready=1 -> out_valid falls next cycle.
- Reset mid-RUN: accept a=0x0F, b=0x01, assert rst asynchronously during the 3rd bit cycle -> out_valid=0, sum=0, cout=0, in_ready=1 immediately. Next op a=0x10, b=0x20, cin=1 -> sum=0x31, cout=0.
- Exhaustive check, WIDTH=2: all 32 combinations of a, b, cin -> {cout,sum} == a+b+cin for each, and out_valid is never high in RUN.
- WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, out_valid 1 cycle after accept.
